// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem requests under req/ready,
// absorbs hazard stalls with a one-entry hold buffer and drains in-flight accesses on redirect.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned PC_INCR     = 1,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ifid_write,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [ADDR_WIDTH-1:0]  ifid_pc,
  output logic [ADDR_WIDTH-1:0]  ifid_pc_next,
  output logic                   ifid_valid
);

  localparam logic [ADDR_WIDTH-1:0] INC   = ADDR_WIDTH'(PC_INCR);
  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]    pend_q, pend_d;
  logic [INSTR_WIDTH-1:0]   hold_q, hold_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]    ipc_q, ipc_d;
  logic [ADDR_WIDTH-1:0]    inext_q, inext_d;
  logic                     ivld_q, ivld_d;
  logic [ADDR_WIDTH-1:0]    pc_inc;
  logic                     hit;

  assign pc_inc       = pc_q + INC;
  assign imem_req     = !reset && (state_q != HOLD);
  assign imem_addr    = pc_q;
  assign hit          = imem_req && imem_ready;
  assign ifid_instr   = instr_q;
  assign ifid_pc      = ipc_q;
  assign ifid_pc_next = inext_q;
  assign ifid_valid   = ivld_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    inext_d = inext_q;
    ivld_d  = ivld_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid && hit) begin
          pc_d   = redirect_pc;
          ivld_d = 1'b0;
        end else if (redirect_valid) begin
          // access cannot be aborted: park the target until memory answers
          pend_d  = redirect_pc;
          ivld_d  = 1'b0;
          state_d = DRAIN;
        end else if (hit && ifid_write) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          inext_d = pc_inc;
          ivld_d  = 1'b1;
          pc_d    = pc_inc;
        end else if (hit) begin
          hold_d  = imem_rdata;
          state_d = HOLD;
        end else if (ifid_write) begin
          ivld_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          ivld_d  = 1'b0;
          state_d = FETCH;
        end else if (ifid_write) begin
          instr_d = hold_q;
          ipc_d   = pc_q;
          inext_d = pc_inc;
          ivld_d  = 1'b1;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        ivld_d = 1'b0;
        if (redirect_valid) pend_d = redirect_pc;
        if (hit) begin
          pc_d    = redirect_valid ? redirect_pc : pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= PC_RST;
      pend_q  <= '0;
      hold_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      inext_q <= '0;
      ivld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      inext_q <= inext_d;
      ivld_q  <= ivld_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, PC wrap, stall/hold, drain and reset cases.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifid_write;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_ready;

  logic        req_m, req_w, req_b;
  logic [15:0] addr_m, addr_w, addr_b;
  logic [15:0] rdata_m, rdata_w, rdata_b;
  logic [15:0] instr_m, instr_w, instr_b;
  logic [15:0] pc_m, pc_w, pc_b;
  logic [15:0] nxt_m, nxt_w, nxt_b;
  logic        vld_m, vld_w, vld_b;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  // memory image: mem[n] = A000 + n
  assign rdata_m = 16'hA000 + addr_m;
  assign rdata_w = 16'hA000 + addr_w;
  assign rdata_b = 16'hA000 + addr_b;

  fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .PC_INCR(1), .RESET_PC(0)) u_main (
    .clock(clock), .reset(reset), .ifid_write(ifid_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req_m), .imem_addr(addr_m), .imem_ready(imem_ready), .imem_rdata(rdata_m),
    .ifid_instr(instr_m), .ifid_pc(pc_m), .ifid_pc_next(nxt_m), .ifid_valid(vld_m));

  fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .PC_INCR(1), .RESET_PC(16'hFFFF)) u_wrap (
    .clock(clock), .reset(reset), .ifid_write(ifid_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ready(imem_ready), .imem_rdata(rdata_w),
    .ifid_instr(instr_w), .ifid_pc(pc_w), .ifid_pc_next(nxt_w), .ifid_valid(vld_w));

  fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .PC_INCR(2), .RESET_PC(16'hFFFE)) u_byte (
    .clock(clock), .reset(reset), .ifid_write(ifid_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(imem_ready), .imem_rdata(rdata_b),
    .ifid_instr(instr_b), .ifid_pc(pc_b), .ifid_pc_next(nxt_b), .ifid_valid(vld_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] instr, input logic [15:0] pc,
                          input logic [15:0] nxt);
    chk({tag, ".vld"},   32'(vld_m),   32'd1);
    chk({tag, ".instr"}, 32'(instr_m), 32'(instr));
    chk({tag, ".pc"},    32'(pc_m),    32'(pc));
    chk({tag, ".next"},  32'(nxt_m),   32'(nxt));
  endtask

  initial begin
    reset = 1'b1; ifid_write = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
    tick; tick;
    chk("rst.req",   32'(req_m),   32'd0);
    chk("rst.vld",   32'(vld_m),   32'd0);
    chk("rst.instr", 32'(instr_m), 32'd0);
    chk("rst.addr",  32'(addr_m),  32'd0);
    chk("rst.waddr", 32'(addr_w),  32'hFFFF);
    reset = 1'b0;
    #1 chk("rel.req", 32'(req_m), 32'd1);

    // sequential fetch and wrap
    tick;
    chk_ifid("seq0", 16'hA000, 16'h0000, 16'h0001);
    chk("seq0.addr",  32'(addr_m), 32'd1);
    chk("wrap.pc",    32'(pc_w),   32'hFFFF);
    chk("wrap.next",  32'(nxt_w),  32'h0000);
    chk("wrap.addr",  32'(addr_w), 32'h0000);
    chk("wrap.instr", 32'(instr_w), 32'hA000 + 32'hFFFF - 32'h10000);
    chk("wrap2.pc",   32'(pc_b),   32'hFFFE);
    chk("wrap2.next", 32'(nxt_b),  32'h0000);
    chk("wrap2.addr", 32'(addr_b), 32'h0000);
    tick; chk_ifid("seq1", 16'hA001, 16'h0001, 16'h0002);
    tick; chk_ifid("seq2", 16'hA002, 16'h0002, 16'h0003);
    tick; tick;
    chk_ifid("seq4", 16'hA004, 16'h0004, 16'h0005);

    // stall while addr 5 returns
    ifid_write = 1'b0;
    tick;
    chk("hold.req",   32'(req_m),   32'd0);
    chk("hold.instr", 32'(instr_m), 32'hA004);
    chk("hold.addr",  32'(addr_m),  32'd5);
    tick; tick;
    chk("hold3.req",   32'(req_m),   32'd0);
    chk("hold3.instr", 32'(instr_m), 32'hA004);
    ifid_write = 1'b1;
    tick;
    chk_ifid("rel5", 16'hA005, 16'h0005, 16'h0006);
    chk("rel5.addr", 32'(addr_m), 32'd6);
    chk("rel5.req",  32'(req_m),  32'd1);
    tick;
    chk_ifid("rel6", 16'hA006, 16'h0006, 16'h0007);

    // redirect coinciding with a hit: data dropped, no drain
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick;
    chk("rhit.vld",  32'(vld_m),  32'd0);
    chk("rhit.addr", 32'(addr_m), 32'h10);
    chk("rhit.req",  32'(req_m),  32'd1);

    // 2-cycle memory; redirect to 0x40 while 0x10 outstanding
    redirect_valid = 1'b0; imem_ready = 1'b0;
    tick;
    chk("wait.vld", 32'(vld_m), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick;
    chk("drain.addr", 32'(addr_m), 32'h10);
    chk("drain.req",  32'(req_m),  32'd1);
    chk("drain.vld",  32'(vld_m),  32'd0);
    redirect_valid = 1'b0; imem_ready = 1'b1;
    tick;
    chk("drain.done.addr", 32'(addr_m), 32'h40);
    chk("drain.done.vld",  32'(vld_m),  32'd0);
    tick;
    chk_ifid("tgt40", 16'hA040, 16'h0040, 16'h0041);

    // two redirects during drain: newest wins
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick;
    redirect_pc = 16'h0080;
    tick;
    chk("drain2.addr", 32'(addr_m), 32'h41);
    redirect_valid = 1'b0; imem_ready = 1'b1;
    tick;
    chk("drain2.done.addr", 32'(addr_m), 32'h80);
    chk("drain2.done.vld",  32'(vld_m),  32'd0);
    tick;
    chk_ifid("tgt80", 16'hA080, 16'h0080, 16'h0081);

    // redirect during HOLD drops the held instruction
    ifid_write = 1'b0;
    tick;
    chk("hold2.req", 32'(req_m), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    tick;
    chk("hredir.addr", 32'(addr_m), 32'h20);
    chk("hredir.req",  32'(req_m),  32'd1);
    chk("hredir.vld",  32'(vld_m),  32'd0);
    redirect_valid = 1'b0; ifid_write = 1'b1;
    tick;
    chk_ifid("tgt20", 16'hA020, 16'h0020, 16'h0021);

    // reset while draining
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0030;
    tick;
    redirect_valid = 1'b0; reset = 1'b1;
    tick;
    chk("rdrain.req",  32'(req_m),  32'd0);
    chk("rdrain.vld",  32'(vld_m),  32'd0);
    chk("rdrain.addr", 32'(addr_m), 32'd0);
    reset = 1'b0; imem_ready = 1'b1;
    tick;
    chk_ifid("rdrain.restart", 16'hA000, 16'h0000, 16'h0001);

    // reset while holding
    ifid_write = 1'b0;
    tick;
    chk("hold3b.req", 32'(req_m), 32'd0);
    reset = 1'b1;
    tick;
    chk("rhold.req",   32'(req_m),   32'd0);
    chk("rhold.vld",   32'(vld_m),   32'd0);
    chk("rhold.instr", 32'(instr_m), 32'd0);
    chk("rhold.addr",  32'(addr_m),  32'd0);
    reset = 1'b0; ifid_write = 1'b1;
    tick;
    chk_ifid("rhold.restart", 16'hA000, 16'h0000, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage for the RISC_PROC pipeline.
- Owns the PC register, PC incrementer and redirect selection.
- Issues requests to instruction memory under a req/ready handshake and drives the IF/ID pipeline register.
- Handles hazard-unit stalls (pc_write/ifid_write style), branch/jump redirects, and variable-latency memory that cannot be aborted mid-request.

Parameters:
ADDR_WIDTH, 16, width of PC and instruction address
INSTR_WIDTH, 16, width of instruction word
PC_INCR, 1, sequential PC increment (1 = word-addressed, 2 = byte-addressed 16-bit instructions)
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
ifid_write  input  1  hazard unit: 1 = IF/ID may load, 0 = stall (hold IF/ID and PC)
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  ADDR_WIDTH  redirect target
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_WIDTH  fetch address, stable while imem_req=1 and imem_ready=0
imem_ready  input  1  memory returns data this cycle (may be combinational from imem_req)
imem_rdata  input  INSTR_WIDTH  instruction data, valid when imem_req & imem_ready
ifid_instr  output  INSTR_WIDTH  IF/ID instruction
ifid_pc  output  ADDR_WIDTH  address of ifid_instr
ifid_pc_next  output  ADDR_WIDTH  ifid_pc + PC_INCR
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset:
  - pc = RESET_PC; state = FETCH; ifid_valid = 0; ifid_instr/ifid_pc/ifid_pc_next = 0; hold and pending registers = 0.
  - imem_req is forced 0 while reset = 1.
  - Reset overrides all other inputs, in every state.
- Datapath:
  - imem_addr = pc in all states.
  - pc_inc = pc + PC_INCR, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - hit = imem_req & imem_ready.
- FSM states: FETCH, HOLD, DRAIN.
- FETCH (imem_req = 1), priority order:
  1. redirect_valid & hit: discard data; pc <= redirect_pc; ifid_valid <= 0; stay FETCH.
  2. redirect_valid & !hit: pend_pc <= redirect_pc; ifid_valid <= 0; go DRAIN. pc and imem_addr unchanged.
  3. hit & ifid_write: ifid_instr <= imem_rdata; ifid_pc <= pc; ifid_pc_next <= pc_inc; ifid_valid <= 1; pc <= pc_inc; stay FETCH.
  4. hit & !ifid_write: hold_instr <= imem_rdata; IF/ID unchanged; go HOLD.
  5. !hit & ifid_write: ifid_valid <= 0 (bubble); stay FETCH.
  6. !hit & !ifid_write: no change.
- HOLD (imem_req = 0):
  - redirect_valid: discard hold_instr; pc <= redirect_pc; ifid_valid <= 0; go FETCH.
  - ifid_write: load IF/ID from hold_instr with pc/pc_inc; ifid_valid <= 1; pc <= pc_inc; go FETCH.
  - else: stay HOLD.
- DRAIN (imem_req = 1, address held at old pc; returned data is never used):
  - Any further redirect_valid overwrites pend_pc (newest wins); ifid_valid <= 0.
  - On hit: pc <= (redirect_valid ? redirect_pc : pend_pc); go FETCH.
  - ifid_valid stays 0 throughout DRAIN.
- Redirect always overrides ifid_write.
- At most one instruction is buffered in HOLD, so no data is lost under stall.
- Throughput and latency:
  - Zero-wait memory: one instruction per cycle.
  - Latency from request acceptance to ifid_valid = 1 edge.
- Redirect-to-target-request latency:
  - 1 cycle from FETCH or HOLD.
  - In DRAIN: the outstanding access completes, then 1 cycle.

Test Plan:
1. Sequential fetch: reset with RESET_PC=0, imem_ready=1, ifid_write=1, mem[n]=16'hA000+n -> consecutive cycles show ifid_instr A000/A001/A002, ifid_pc 0/1/2, ifid_pc_next 1/2/3, ifid_valid=1 from first post-reset edge.
2. Wrap-around: RESET_PC=16'hFFFF -> ifid_pc=FFFF, ifid_pc_next=0000, next imem_addr=0000. Repeat with PC_INCR=2, RESET_PC=FFFE -> pc_next 0000.
3. Stall/HOLD: ifid_write=0 for 3 cycles while addr 5 returns -> imem_req=0 in HOLD, IF/ID keeps addr 4 instruction. On release, IF/ID = mem[5] on next edge, then imem_addr=6; no duplicate or lost instruction.
4. Redirect in DRAIN: 2-cycle memory, redirect_valid to 16'h0040 while addr 0010 is outstanding -> imem_addr stays 0010 until ready, data discarded, ifid_valid=0. Next request at 0040; IF/ID then shows mem[0x40].
5. Redirect collisions:
   - redirect during HOLD -> hold_instr dropped, next imem_addr = redirect_pc.
   - redirect with hit in FETCH -> data dropped, no DRAIN.
   - second redirect in DRAIN (0040 then 0080) -> fetch resumes at 0080.
6. Reset mid-operation: assert reset in DRAIN and in HOLD -> next edge: imem_req=0 during reset, ifid_valid=0, pc=RESET_PC; fetch restarts at RESET_PC after release.
